// File: rtl/gdp_pkg.sv
// gdp_pkg: shared word type, default sizing and FSM encoding for the gdp sequencer
package gdp_pkg;
    typedef logic [15:0] gdp_word_t;
    localparam int GDP_N_COMP   = 39;
    localparam int GDP_N_STATES = 8;
    localparam int GDP_LAT_DEF  = 4;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} gdp_state_t;
endpackage

// File: rtl/gdp_addr_gen.sv
// gdp_addr_gen: component/state counters, RAM addresses and data-aligned first/last flags
module gdp_addr_gen
    import gdp_pkg::*;
#(
    parameter int N_COMP   = GDP_N_COMP,
    parameter int N_STATES = GDP_N_STATES,
    localparam int CW = $clog2(N_COMP),
    localparam int SW = $clog2(N_STATES),
    localparam int PW = $clog2(N_STATES * N_COMP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] obs_addr,
    output logic [PW-1:0] par_addr,
    output logic [SW-1:0] k_addr,
    output logic          last_item,
    output logic          first_calc,
    output logic          last_calc
);
    logic last_c;
    assign last_c    = obs_addr == CW'(N_COMP - 1);
    assign last_item = en && last_c && k_addr == SW'(N_STATES - 1);
    // walk (state, comp) with comp fastest; flags lag one cycle to line up with RAM read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            obs_addr   <= '0;
            par_addr   <= '0;
            k_addr     <= '0;
            first_calc <= 1'b0;
            last_calc  <= 1'b0;
        end else begin
            first_calc <= en && obs_addr == '0;
            last_calc  <= en && last_c;
            if (en) begin
                obs_addr <= last_c ? '0 : obs_addr + 1'b1;
                k_addr   <= last_c ? (k_addr == SW'(N_STATES - 1) ? '0 : k_addr + 1'b1) : k_addr;
                par_addr <= last_item ? '0 : par_addr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/gdp_sequencer.sv
// gdp_sequencer: feeds one frame of operands into gdp and tags returned scores; GDP_SEQ_BEST_EN adds best-score/timeout outputs
module gdp_sequencer
    import gdp_pkg::*;
#(
    parameter int N_COMP   = GDP_N_COMP,
    parameter int N_STATES = GDP_N_STATES,
    parameter int GDP_LAT  = GDP_LAT_DEF,
    localparam int CW = $clog2(N_COMP),
    localparam int SW = $clog2(N_STATES),
    localparam int PW = $clog2(N_STATES * N_COMP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] obs_addr,
    input  gdp_word_t     obs_data,
    output logic [PW-1:0] par_addr,
    input  gdp_word_t     mean_data,
    input  gdp_word_t     omega_data,
    output logic [SW-1:0] k_addr,
    input  gdp_word_t     k_data,
    output logic          first_calc,
    output logic          last_calc,
    output gdp_word_t     x,
    output gdp_word_t     mean,
    output gdp_word_t     omega,
    output gdp_word_t     k,
    input  gdp_word_t     ln_p,
    input  logic          data_ready,
    output logic          score_valid,
    output gdp_word_t     score,
    output logic [SW-1:0] score_state
`ifdef GDP_SEQ_BEST_EN
    ,
    output gdp_word_t     best_score,
    output logic [SW-1:0] best_state,
    output logic          timeout
`endif
);
    localparam int TO = GDP_LAT + N_COMP;
    localparam int RW = $clog2(N_STATES + 1);
    localparam int DW = $clog2(TO + 1);

    if (N_COMP < 2) begin : g_bad_comp
        $error("gdp_sequencer: N_COMP must be >= 2");
    end

    gdp_state_t    state, nxt;
    logic [RW-1:0] rcnt;
    logic [DW-1:0] dcnt;
    logic          last_item, fin, to_hit, capture, go;

    assign x       = obs_data;
    assign mean    = mean_data;
    assign omega   = omega_data;
    assign k       = k_data;
    assign busy    = state != IDLE;
    assign go      = state == IDLE && start;
    assign capture = data_ready && busy;
    assign to_hit  = dcnt == DW'(TO);
    assign fin     = rcnt == RW'(N_STATES) || (data_ready && rcnt == RW'(N_STATES - 1));

    gdp_addr_gen #(.N_COMP(N_COMP), .N_STATES(N_STATES)) u_addr (
        .clk       (clk),
        .reset     (reset),
        .en        (state == STREAM),
        .obs_addr  (obs_addr),
        .par_addr  (par_addr),
        .k_addr    (k_addr),
        .last_item (last_item),
        .first_calc(first_calc),
        .last_calc (last_calc)
    );

    // frame sequencing: stream all items, then wait for the last score or the drain timeout
    always_comb begin
        nxt = state == IDLE   ? (start ? STREAM : IDLE) :
              state == STREAM ? (last_item ? DRAIN : STREAM) :
              (fin || to_hit) ? IDLE : DRAIN;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // capture gdp results in arrival order, count drain cycles and flag frame completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done        <= 1'b0;
            score_valid <= 1'b0;
            score       <= '0;
            score_state <= '0;
            rcnt        <= '0;
            dcnt        <= '0;
        end else begin
            done        <= state == DRAIN && nxt == IDLE;
            score_valid <= capture;
            dcnt        <= state == DRAIN ? dcnt + 1'b1 : '0;
            if (go) begin
                rcnt <= '0;
            end else if (capture) begin
                score       <= ln_p;
                score_state <= rcnt[SW-1:0];
                rcnt        <= rcnt == RW'(N_STATES) ? rcnt : rcnt + 1'b1;
            end
        end
    end

`ifdef GDP_SEQ_BEST_EN
    // running signed maximum; strict compare keeps the earlier (lower) state on ties
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_score <= '0;
            best_state <= '0;
            timeout    <= 1'b0;
        end else if (go) begin
            best_score <= 16'h8000;
            best_state <= '0;
            timeout    <= 1'b0;
        end else begin
            if (capture && $signed(ln_p) > $signed(best_score)) begin
                best_score <= ln_p;
                best_state <= rcnt[SW-1:0];
            end
            if (state == DRAIN && to_hit && !fin) timeout <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_gdp_sequencer.sv
// tb_gdp_sequencer: directed, table-driven bench with RAM and latency-4 gdp models
module tb_gdp_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, busy, done, first_calc, last_calc, score_valid, data_ready;
    logic [1:0]  obs_addr;
    logic [2:0]  par_addr;
    logic [0:0]  k_addr, score_state;
    logic [15:0] obs_data, mean_data, omega_data, k_data, x, mean, omega, k, ln_p, score;
`ifdef GDP_SEQ_BEST_EN
    logic [15:0] best_score;
    logic [0:0]  best_state;
    logic        timeout;
`endif
    logic        inj, withhold;
    logic [15:0] vals [2];
    logic [3:0]  lc_pipe = '0;
    logic [3:0]  tag_pipe = '0;
    int          n_chk = 0, n_fail = 0;
    logic [2:0]  par_log [1:40];
    logic [0:0]  sv_state [4];
    logic [15:0] sv_score [4];

    typedef struct packed {
        logic       busy, done;
        logic [2:0] par;
        logic [1:0] obs;
        logic       kad, fc, lc, sv, ss;
        logic [15:0] sc;
    } row_t;
    row_t rows [1:14];

    always #5 clk = ~clk;

    gdp_sequencer #(.N_COMP(4), .N_STATES(2), .GDP_LAT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .obs_addr(obs_addr), .obs_data(obs_data), .par_addr(par_addr),
        .mean_data(mean_data), .omega_data(omega_data), .k_addr(k_addr), .k_data(k_data),
        .first_calc(first_calc), .last_calc(last_calc), .x(x), .mean(mean), .omega(omega), .k(k),
        .ln_p(ln_p), .data_ready(data_ready), .score_valid(score_valid), .score(score),
        .score_state(score_state)
`ifdef GDP_SEQ_BEST_EN
        , .best_score(best_score), .best_state(best_state), .timeout(timeout)
`endif
    );

    // synchronous RAMs with address-derived contents
    always @(posedge clk) begin
        obs_data   <= 16'hA000 | 16'(obs_addr);
        mean_data  <= 16'h1000 + 16'(par_addr);
        omega_data <= 16'h2000 + 16'(par_addr);
        k_data     <= 16'h3000 + 16'(k_addr);
    end

    // gdp model: result 4 cycles after last_calc, tagged with the state carried in k
    always @(posedge clk) begin
        lc_pipe  <= {lc_pipe[2:0], last_calc};
        tag_pipe <= {tag_pipe[2:0], k[0]};
    end
    assign data_ready = (lc_pipe[3] && !(withhold && tag_pipe[3])) || inj;
    assign ln_p       = vals[tag_pipe[3]];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic row_t mk(input bit b, input bit d, input int p, input int o, input bit kk,
                                input bit f, input bit l, input bit v, input bit s, input logic [15:0] sc);
        mk.busy = b; mk.done = d; mk.par = 3'(p); mk.obs = 2'(o); mk.kad = kk;
        mk.fc = f; mk.lc = l; mk.sv = v; mk.ss = s; mk.sc = sc;
    endfunction

    task automatic run_frame(input bit spam, output int dc, output int ns);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dc = -1;
        ns = 0;
        for (int cy = 1; cy <= 40 && dc < 0; cy++) begin
            @(negedge clk);
            par_log[cy] = par_addr;
            if (score_valid && ns < 4) begin
                sv_state[ns] = score_state;
                sv_score[ns] = score;
                ns++;
            end
            if (done) dc = cy;
            start = spam && (cy == 3 || cy == 6 || cy == 12);
        end
        start = 1'b0;
    endtask

    initial begin
        int dc, ns, bad;
        logic [23:0] pl;
        row_t a;
        rows[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        rows[2]  = mk(1, 0, 1, 1, 0, 1, 0, 0, 0, 16'h0000);
        rows[3]  = mk(1, 0, 2, 2, 0, 0, 0, 0, 0, 16'h0000);
        rows[4]  = mk(1, 0, 3, 3, 0, 0, 0, 0, 0, 16'h0000);
        rows[5]  = mk(1, 0, 4, 0, 1, 0, 1, 0, 0, 16'h0000);
        rows[6]  = mk(1, 0, 5, 1, 1, 1, 0, 0, 0, 16'h0000);
        rows[7]  = mk(1, 0, 6, 2, 1, 0, 0, 0, 0, 16'h0000);
        rows[8]  = mk(1, 0, 7, 3, 1, 0, 0, 0, 0, 16'h0000);
        rows[9]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000);
        rows[10] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 16'hFF00);
        rows[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFF00);
        rows[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFF00);
        rows[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFF00);
        rows[14] = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 16'hFFF0);
        reset = 1'b0; start = 1'b0; inj = 1'b0; withhold = 1'b0;
        vals[0] = 16'hFF00; vals[1] = 16'hFFF0;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({busy, done, par_addr, obs_addr, k_addr, first_calc, last_calc,
                                score_valid, score_state, score}), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            a = '{busy, done, par_addr, obs_addr, k_addr, first_calc, last_calc, score_valid, score_state, score};
            chk($sformatf("frame1_cyc%0d", i), 64'(a), 64'(rows[i]));
            if (i >= 2 && i <= 9)
                chk($sformatf("operands_cyc%0d", i), {x, mean, omega, k},
                    {16'hA000 | 16'((i - 2) % 4), 16'h1000 + 16'(i - 2), 16'h2000 + 16'(i - 2),
                     16'h3000 + 16'((i - 2) / 4)});
        end
`ifdef GDP_SEQ_BEST_EN
        chk("frame1_best", 64'({best_state, best_score, timeout}), 64'({1'b1, 16'hFFF0, 1'b0}));
`endif
        vals[0] = 16'h8001; vals[1] = 16'h8001;
        run_frame(1'b0, dc, ns);
        chk("tie_frame", {8'(dc), 8'(ns), 6'd0, sv_state[0], sv_state[1], sv_score[0], sv_score[1]},
            {8'd14, 8'd2, 6'd0, 1'b0, 1'b1, 16'h8001, 16'h8001});
`ifdef GDP_SEQ_BEST_EN
        chk("tie_best", 64'({best_state, best_score}), 64'({1'b0, 16'h8001}));
`endif
        vals[0] = 16'h0001; vals[1] = 16'hFFFF;
        run_frame(1'b0, dc, ns);
        chk("sign_frame", {8'(dc), 8'(ns), 16'd0, sv_score[0], sv_score[1]},
            {8'd14, 8'd2, 16'd0, 16'h0001, 16'hFFFF});
`ifdef GDP_SEQ_BEST_EN
        chk("sign_best", 64'({best_state, best_score}), 64'({1'b0, 16'h0001}));
`endif
        run_frame(1'b1, dc, ns);
        pl = '0;
        for (int j = 1; j <= 8; j++) pl = {pl[20:0], par_log[j]};
        chk("start_while_busy", 64'({8'(dc), 8'(ns), pl}), 64'({8'd14, 8'd2, 24'h053977}));
        @(posedge clk);
        #1;
        run_frame(1'b0, dc, ns);
        chk("start_after_done", 64'({8'(dc), par_log[1], par_log[2]}), 64'({8'd14, 3'd0, 3'd1}));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midframe_reset", 64'({busy, done, par_addr, obs_addr, k_addr, first_calc, last_calc,
                                   score_valid, score_state, score}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (score_valid || done || busy) bad++;
        end
        chk("late_ready_ignored", 64'({8'(bad), score}), 64'({8'd0, 16'h0000}));
        vals[0] = 16'hFF00; vals[1] = 16'hFFF0; withhold = 1'b1;
        run_frame(1'b0, dc, ns);
        chk("drain_timeout", 64'({8'(dc), 8'(ns), sv_score[0]}), 64'({8'd18, 8'd1, 16'hFF00}));
`ifdef GDP_SEQ_BEST_EN
        chk("timeout_flag", 64'({timeout, best_state, best_score}), 64'({1'b1, 1'b0, 16'hFF00}));
`endif
        withhold = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
